fifo_drain_pack: RTL

- Downstream stage of the 16-bit synchronous FIFO: drains the FIFO through its read port (rd_en / registered dout, one-cycle read latency).
- Packs pairs of DW-bit words into 2*DW-bit beats and presents them on a valid/ready stream.
- A flush request forces out a trailing odd word as a partial beat, so packets can be closed cleanly.
- Sits between the FIFO and the 32-bit consumer datapath.

---
 rtl/fifo_drain_pack.sv | 113 +++++++++++
 1 files changed

// File: rtl/fifo_drain_pack.sv
// Drains a synchronous FIFO (one-cycle read latency) and packs word pairs into
// 2*DW-bit valid/ready beats; a flush closes a packet with a partial beat.
module fifo_drain_pack #(
   parameter int DW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            fifo_empty,
   output logic            fifo_rd_en,
   input  logic [DW-1:0]   fifo_dout,
   input  logic            flush,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [2*DW-1:0] m_data,
   output logic [1:0]      m_keep,
   output logic            m_last,
   output logic            flush_done
);

   logic [DW-1:0] slot0_r;
   logic [DW-1:0] slot1_r;
   logic [1:0]    pack_cnt_r;
   logic          inflight_r;
   logic          flush_pend_r;

   logic          full_s;
   logic          drain_s;
   logic          part_xfer_s;
   logic          out_free_s;
   logic          xfer_s;
   logic [1:0]    base_cnt_s;
   logic [2:0]    occ_s;
   logic          rd_en_s;
   logic          flush_cmpl_s;

   // Transfer decision, read issue and flush completion from registered state.
   always_comb begin
      full_s       = (pack_cnt_r == 2'd2);
      drain_s      = flush_pend_r & fifo_empty & ~inflight_r;
      part_xfer_s  = drain_s & (pack_cnt_r == 2'd1);
      out_free_s   = ~m_valid | m_ready;
      xfer_s       = (full_s | part_xfer_s) & out_free_s;
      // A transfer empties the pack register before this cycle's capture lands.
      if (xfer_s) begin
         base_cnt_s = 2'd0;
      end else begin
         base_cnt_s = pack_cnt_r;
      end
      occ_s        = {1'b0, base_cnt_s} + {2'b00, inflight_r};
      // Gated by rst_n so the FIFO is never popped while this stage is held in reset.
      rd_en_s      = rst_n & ~fifo_empty & (occ_s < 3'd2);
      flush_cmpl_s = (part_xfer_s & xfer_s) | (drain_s & (pack_cnt_r == 2'd0));
   end

   assign fifo_rd_en = rd_en_s;

   // Pack register capture, read-latency tracking and flush request latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0_r      <= '0;
         slot1_r      <= '0;
         pack_cnt_r   <= 2'd0;
         inflight_r   <= 1'b0;
         flush_pend_r <= 1'b0;
      end else begin
         if (inflight_r) begin
            if (base_cnt_s == 2'd0) begin
               slot0_r <= fifo_dout;
            end else begin
               slot1_r <= fifo_dout;
            end
         end
         pack_cnt_r <= base_cnt_s + {1'b0, inflight_r};
         inflight_r <= rd_en_s;
         // A pulse arriving while a flush is pending is absorbed.
         if (flush_pend_r) begin
            flush_pend_r <= ~flush_cmpl_s;
         end else begin
            flush_pend_r <= flush;
         end
      end
   end

   // Output beat register with valid/ready hold and flush completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_keep     <= 2'b00;
         m_last     <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         if (xfer_s) begin
            m_valid <= 1'b1;
            if (full_s) begin
               m_data <= {slot1_r, slot0_r};
               m_keep <= 2'b11;
               m_last <= 1'b0;
            end else begin
               m_data <= {{DW{1'b0}}, slot0_r};
               m_keep <= 2'b01;
               m_last <= 1'b1;
            end
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end else begin
            m_valid <= m_valid;
         end
         flush_done <= flush_cmpl_s;
      end
   end

endmodule
